// File: rtl/fetch_pkg.sv
// Shared widths, reset address and the queue entry type for the instruction-fetch stage.
package fetch_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_W    = 8;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [WORD_SIZE-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetched {pc, instr} words with a flush.
// When empty, the head output keeps showing the last word that was presented.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    fetch_entry_t  r_hold;
    fetch_entry_t  w_headData;

    assign o_full     = (r_count == FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign w_headData = o_empty ? r_hold : r_mem[r_head];
    assign o_head     = w_headData;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_tail] <= i_data;
        end
    end

    // r_hold tracks whatever was on the head output so it can be replayed while empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            r_hold <= w_headData;
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (i_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (i_pop) begin
                    r_head <= r_head + 1'b1;
                end
                if (i_push && !i_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (i_pop && !i_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, memory read address, fetch queue and redirect handling.
// Optional perf counters fetch_count/stall_count are built when INSTR_FETCH_PERF_EN is defined.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_W-1:0]    instr_read_address,
    input  logic [WORD_SIZE-1:0] instr_instruction,
    input  logic                 halt,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_instr,
    output logic [ADDR_W-1:0]    out_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [31:0]          stall_count
`endif
);

    logic [ADDR_W-1:0] r_pc;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    fetch_entry_t      w_wrEntry;
    fetch_entry_t      w_head;

    // A redirect discards the offered head, so it never counts as a pop.
    assign w_pop  = out_valid & out_ready & ~redirect;
    assign w_push = ~redirect & ~halt & (~w_full | w_pop);

    always_comb begin
        w_wrEntry       = '0;
        w_wrEntry.pc    = r_pc;
        w_wrEntry.instr = instr_instruction;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_wrEntry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign instr_read_address = r_pc;
    assign out_valid          = ~w_empty;
    assign out_instr          = w_head.instr;
    assign out_pc             = w_head.pc;

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] r_fetchCount;
    logic [31:0] r_stallCount;
    logic        w_stall;

    assign w_stall = ~redirect & ~halt & w_full & ~w_pop;

    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetchCount <= '0;
            r_stallCount <= '0;
        end else begin
            if (w_push) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end
            if (w_stall) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetchCount;
    assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for streaming/stall, then hand sequences
// for redirect, PC wrap, halt drain and reset during redirect.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        halt        = 1'b0;
    logic        redirect    = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        out_ready   = 1'b0;
    logic [7:0]  instr_read_address;
    logic [31:0] instr_instruction;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int nApplied    = 0;
    int nMiscompares = 0;

    typedef struct {
        logic        rst;
        logic        halt;
        logic        redirect;
        logic [7:0]  rpc;
        logic        ready;
        logic        expValid;
        logic [7:0]  expPc;
        logic [31:0] expInstr;
        logic [7:0]  expAddr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // Memory model: word[a] = a + 100.
    assign instr_instruction = 32'(instr_read_address) + 32'd100;

    instr_fetch #(
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .instr_read_address (instr_read_address),
        .instr_instruction  (instr_instruction),
        .halt               (halt),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_instr          (out_instr),
        .out_pc             (out_pc)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .fetch_count        (fetch_count),
        .stall_count        (stall_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iRst, input logic iHalt, input logic iRedirect,
                                 input logic [7:0] iRpc, input logic iReady);
        rst         = iRst;
        halt        = iHalt;
        redirect    = iRedirect;
        redirect_pc = iRpc;
        out_ready   = iReady;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [7:0] expPc,
                               input logic [31:0] expInstr, input logic [7:0] expAddr);
        checkField({tag, ".valid"}, 32'(out_valid), 32'(expValid));
        checkField({tag, ".addr"},  32'(instr_read_address), 32'(expAddr));
        checkField({tag, ".pc"},    32'(out_pc), 32'(expPc));
        checkField({tag, ".instr"}, out_instr, expInstr);
    endtask

    initial begin
        //                rst  halt redir rpc    rdy  valid pc     instr    addr
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'd0,   8'h00});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'd0,   8'h00});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'd100, 8'h01});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 32'd101, 8'h02});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 32'd102, 8'h03});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 32'd103, 8'h04});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 32'd103, 8'h05});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 32'd103, 8'h06});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 32'd103, 8'h07});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 32'd103, 8'h07});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 32'd104, 8'h08});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 32'd105, 8'h09});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 32'd106, 8'h0A});

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].halt, vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expInstr, vecs[i].expAddr);
            tick();
        end

        // Fill from reset with decode stalled for 10 cycles, then drain.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        checkOutput("stallFill", 1'b1, 8'h00, 32'd100, 8'h04);
`ifdef INSTR_FETCH_PERF_EN
        checkField("fetchCount", fetch_count, 32'd4);
        checkField("stallCount", stall_count, 32'd6);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("drain%0d", k), 1'b1, 8'(k), 32'(k) + 32'd100, 8'(k + 4));
            tick();
        end

        // Redirect with three queued entries and decode ready: head is discarded.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("preRedir", 1'b1, 8'h00, 32'd100, 8'h03);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, 1'b1);
        tick();
        checkField("redirN1.valid", 32'(out_valid), 32'd0);
        checkField("redirN1.addr", 32'(instr_read_address), 32'h40);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("redirN2", 1'b1, 8'h40, 32'd164, 8'h41);
        tick();
        checkOutput("redirN3", 1'b1, 8'h41, 32'd165, 8'h42);

        // Redirect beats halt; then free-run across the 8'hFF -> 8'h00 wrap.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE, 1'b1);
        tick();
        checkField("wrapRedir.valid", 32'(out_valid), 32'd0);
        checkField("wrapRedir.addr", 32'(instr_read_address), 32'hFE);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("wrap0", 1'b1, 8'hFE, 32'd354, 8'hFF);
        tick();
        checkOutput("wrap1", 1'b1, 8'hFF, 32'd355, 8'h00);
        tick();
        checkOutput("wrap2", 1'b1, 8'h00, 32'd100, 8'h01);
        tick();
        checkOutput("wrap3", 1'b1, 8'h01, 32'd101, 8'h02);

        // Halt with two queued entries: both drain, PC frozen.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("halt0", 1'b1, 8'h00, 32'd100, 8'h02);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("halt1", 1'b1, 8'h01, 32'd101, 8'h02);
        tick();
        checkField("halt2.valid", 32'(out_valid), 32'd0);
        checkField("halt2.addr", 32'(instr_read_address), 32'h02);
        tick();
        checkField("halt3.valid", 32'(out_valid), 32'd0);
        checkField("halt3.addr", 32'(instr_read_address), 32'h02);

        // Reset asserted together with a redirect: reset wins.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
        tick();
        checkOutput("rstRedir", 1'b0, 8'h00, 32'd0, 8'h00);
`ifdef INSTR_FETCH_PERF_EN
        checkField("rstFetchCount", fetch_count, 32'd0);
        checkField("rstStallCount", stall_count, 32'd0);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("postRst", 1'b1, 8'h00, 32'd100, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage directly upstream of the unified CPU memory. Holds the program counter, drives the memory's 8-bit word-addressed instruction read port (combinational, same-cycle data), and buffers fetched words with their PC in a small queue. The decode stage consumes the queue through a valid/ready handshake. Branch/jump redirects flush the queue and restart fetch.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- RESET_PC, 8'h00: PC loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- instr_read_address  out  8  word address to memory instruction port; equals PC
- instr_instruction  in  32  instruction word returned combinationally for instr_read_address
- halt  in  1  1 = stop fetching; queue still drains
- redirect  in  1  1 = flush queue, load PC from redirect_pc
- redirect_pc  in  8  new fetch address
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  8  head PC
- fetch_count  out  32  only with INSTR_FETCH_PERF_EN
- stall_count  out  32  only with INSTR_FETCH_PERF_EN

## Operation
- Reset (rst=0 at rising edge): PC←RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, counters 0. Reset wins over all inputs, including mid-redirect or mid-handshake.
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & ~halt & (count<DEPTH | pop). Full queue with a same-cycle pop still pushes (full throughput).
- On push: write {PC, instr_instruction} at tail; PC←PC+1, wrapping 8'hFF→8'h00.
- On pop: advance head. Push and pop together leave count unchanged.
- redirect=1: count←0, head/tail reset, PC←redirect_pc; no push. Any head offered that cycle is discarded even if out_ready=1; decode must not treat it as accepted. redirect has priority over halt.
- halt=1 (no redirect): PC holds, no push, pops continue.
- out_instr/out_pc hold the last value when the queue is empty. Only out_valid qualifies them.
- instr_read_address = PC at all times, including halt and full.

## Timing
- Cycle 0 = first edge with rst=1. The queue captures the RESET_PC word at the end of cycle 0. out_valid=1 in cycle 1.
- Redirect sampled at edge N: first push of the target occurs in cycle N+1. Target visible on out_* with out_valid=1 in cycle N+2 (2-cycle redirect penalty).
- Steady state, no stalls: one instruction per cycle, fetch-to-out latency 1 cycle.
- out_* are registered/storage outputs, with no combinational path from out_ready. push depends combinationally on out_ready, through the full-with-pop case only.
- Count range 0..DEPTH; never overflows or underflows.

## Configuration
- INSTR_FETCH_PERF_EN defined: fetch_count and stall_count ports and logic exist.
  - fetch_count +1 per push.
  - stall_count +1 per cycle with ~redirect & ~halt & full & ~pop.
  - Both wrap at 2^32. Cleared only by reset, not by redirect.
- Not defined: ports and counter logic absent; all other behaviour identical.

## Structure
- Package fetch_pkg:
  - WORD_SIZE=32, ADDR_W=8
  - typedef fetch_entry_t {pc[7:0], instr[31:0]}
  - RESET_PC default constant
- Sub-module fetch_queue: DEPTH-entry synchronous FIFO of fetch_entry_t. Ports: push, pop, flush, full, empty, head data. instr_fetch owns PC, push/pop/redirect arbitration and the perf counters.

## Test plan
- Reset, then out_ready=1, memory word[i]=i+100: out_pc 0,1,2,… with out_instr 100,101,… starting in cycle 1, one per cycle.
- out_ready=0 for 10 cycles: exactly DEPTH=4 entries fill; PC holds at 4; stall_count=6. Then out_ready=1: pcs 0..3 then 4.., with no gaps or duplicates.
- Full queue, out_ready=1 in the same cycle as push: count stays 4 and PC advances.
- redirect with redirect_pc=8'h40 while queue holds 3 entries and out_ready=1: the head is not consumed. out_valid=0 in cycle N+1; out_pc=8'h40 with word[0x40] in cycle N+2.
- PC at 8'hFE, free-running: fetches 8'hFE, 8'hFF, 8'h00, 8'h01.
- halt=1 with 2 queued entries: both drain, then out_valid=0 and instr_read_address is constant. rst=0 asserted during a redirect: next cycle PC=RESET_PC and queue empty.
